// File: rtl/aes_pkg.sv
// Shared AES constants and small elaboration-time helpers.
package aes_pkg;

  localparam int AES_BLOCK_W           = 128;
  localparam int AES128_NUM_ROUND_KEYS = 11;

  // Beat widths the streaming stages know how to slice a block into.
  function automatic bit lane_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/round_key_bank.sv
// Round-key storage: one 128-bit register per round, one write port and one
// combinational read port. Out-of-range addresses write nothing and read zero.
module round_key_bank
  import aes_pkg::*;
#(
  parameter int NUM_KEYS = AES128_NUM_ROUND_KEYS,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  logic [AES_BLOCK_W-1:0] wdata,
  input  logic [IDX_W-1:0]       raddr,
  output logic [AES_BLOCK_W-1:0] rdata,
  output logic                   rvalid
);

  logic [AES_BLOCK_W-1:0] keys [NUM_KEYS];

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_entry
    logic [AES_BLOCK_W-1:0] key_reg;

    // Entry loads only when the write address decodes to it, so addresses
    // at or above NUM_KEYS never touch any entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        key_reg <= '0;
      end else if (we && (waddr == IDX_W'(gi))) begin
        key_reg <= wdata;
      end
    end

    assign keys[gi] = key_reg;
  end

  assign rvalid = (int'(raddr) < NUM_KEYS);

  // Read mux; reads the registered value, so a same-cycle write is not seen.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (raddr == IDX_W'(i)) begin
        rdata = keys[i];
      end
    end
  end

endmodule

// File: rtl/addroundkey_stream.sv
// Streaming AES AddRoundKey: XORs a 128-bit state delivered MSB-first in
// LANE_W-bit beats with the round key chosen by the index on beat 0.
module addroundkey_stream
  import aes_pkg::*;
#(
  parameter  int LANE_W   = 32,
  parameter  int NUM_KEYS = AES128_NUM_ROUND_KEYS,
  localparam int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_we,
  input  logic [IDX_W-1:0]       key_waddr,
  input  logic [AES_BLOCK_W-1:0] key_wdata,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANE_W-1:0]      in_data,
  input  logic [IDX_W-1:0]       in_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANE_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   err_round
);

  localparam int BEATS = AES_BLOCK_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (!lane_w_legal(LANE_W) || ((AES_BLOCK_W % LANE_W) != 0)) begin : g_bad_lane_w
    $error("addroundkey_stream: LANE_W must be 8, 16, 32, 64 or 128");
  end

  logic [0:0]             state_reg;
  logic [CNT_W-1:0]       beat_cnt_reg;
  logic [AES_BLOCK_W-1:0] snapshot_reg;
  logic [LANE_W-1:0]      out_data_reg;
  logic                   out_valid_reg;
  logic                   out_last_reg;
  logic                   err_round_reg;

  logic [AES_BLOCK_W-1:0] bank_rdata;
  logic                   bank_rvalid;
  logic [AES_BLOCK_W-1:0] key_cur;
  logic [LANE_W-1:0]      key_slices [BEATS];
  logic [LANE_W-1:0]      key_lane;
  logic                   accept;

  round_key_bank #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (key_we),
    .waddr  (key_waddr),
    .wdata  (key_wdata),
    .raddr  (in_round),
    .rdata  (bank_rdata),
    .rvalid (bank_rvalid)
  );

  // Output register frees up whenever it is empty or being drained.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Beat 0 uses the live bank read; later beats use the block's snapshot so
  // key writes during a block cannot disturb it.
  assign key_cur = (state_reg == IDLE) ? bank_rdata : snapshot_reg;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign key_slices[gi] = key_cur[AES_BLOCK_W-1-gi*LANE_W -: LANE_W];
  end

  if (BEATS == 1) begin : g_one_beat
    assign key_lane = key_slices[0];
  end else begin : g_multi_beat
    assign key_lane = key_slices[beat_cnt_reg];
  end

  // Block framing: IDLE owns beat 0 and captures the key, BUSY the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      snapshot_reg <= '0;
    end else if (accept) begin
      if (state_reg == IDLE) begin
        snapshot_reg <= bank_rdata;
      end
      if (beat_cnt_reg == LAST_BEAT) begin
        state_reg    <= IDLE;
        beat_cnt_reg <= '0;
      end else begin
        state_reg    <= BUSY;
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Output stage: load on accept, hold while stalled, empty when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      err_round_reg <= 1'b0;
    end else begin
      err_round_reg <= accept && (state_reg == IDLE) && !bank_rvalid;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data ^ key_lane;
        out_last_reg  <= (beat_cnt_reg == LAST_BEAT);
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign err_round = err_round_reg;

endmodule

// File: tb/tb_addroundkey_stream.sv
// Testbench for addroundkey_stream: a 32-bit lane instance driven with
// directed and random blocks, plus a 128-bit lane instance for single-beat blocks.
module tb_addroundkey_stream;

  localparam int NK = 11;
  localparam logic [127:0] K0   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ST0  = 128'h591ceea1c28636d1caddaf024a27dca2;
  localparam logic [127:0] EXP0 = 128'h3b7f8dc2a0e555b2a8becc612844bfc1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;

  logic         in_valid, in_ready, out_valid, out_ready, out_last, err_round;
  logic [31:0]  in_data, out_data;
  logic [3:0]   in_round;

  logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_last_w, err_round_w;
  logic [127:0] in_data_w, out_data_w;
  logic [3:0]   in_round_w;

  addroundkey_stream #(.LANE_W(32), .NUM_KEYS(NK)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_round(err_round)
  );

  addroundkey_stream #(.LANE_W(128), .NUM_KEYS(NK)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w), .in_round(in_round_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .out_last(out_last_w), .err_round(err_round_w)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int err_cnt = 0;

  // Reference model: the key bank as the writer sees it.
  logic [127:0] model_key [NK];

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } beat_t;
  beat_t obs_q[$];

  // Monitor: record every delivered output beat and every error pulse.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) obs_q.push_back({out_data, out_last});
    if (rst_n && err_round) err_cnt++;
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected ciphertext-state of one block: state XOR the selected key, or
  // unchanged when the round index has no key.
  function automatic logic [127:0] ref_block(input logic [127:0] st, input int r);
    if (r < NK) return st ^ model_key[r];
    return st;
  endfunction

  task automatic write_key(input logic [3:0] addr, input logic [127:0] data);
    key_we = 1'b1; key_waddr = addr; key_wdata = data;
    @(posedge clk); #1;
    key_we = 1'b0;
    if (int'(addr) < NK) model_key[addr] = data;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] r, input bit rnd, output bit ok);
    int guard = 0;
    bit acc;
    in_valid = 1'b1; in_data = d; in_round = r; ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      ok = acc; guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] st, input logic [3:0] r, input bit rnd, output bit ok);
    bit okb;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      drive_beat(st[127-32*k -: 32], (k == 0) ? r : 4'($urandom_range(0, 15)), rnd, okb);
      if (!okb) begin ok = 1'b0; break; end
    end
  endtask

  task automatic collect_block(output logic [127:0] data, output logic [3:0] lasts, output bit ok);
    int guard = 0;
    beat_t b;
    while (obs_q.size() < 4 && guard < 200) begin @(negedge clk); guard++; end
    ok = (obs_q.size() >= 4); data = '0; lasts = '0;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        b = obs_q.pop_front();
        data = {data[95:0], b.d};
        lasts = {lasts[2:0], b.last};
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %b want 0", out_last); end
    tests_run++; if (err_round !== 1'b0) begin tests_failed++; $display("FAIL reset_err_round got %b want 0", err_round); end
    tests_run++; if (out_valid_w !== 1'b0 || out_data_w !== 128'h0) begin tests_failed++; $display("FAIL reset_wide got v=%b d=%h want 0", out_valid_w, out_data_w); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_known_vector();
    logic [127:0] st, ex;
    st = ST0; ex = EXP0;
    write_key(4'd0, K0);
    out_ready = 1'b1; obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = st[127-32*k -: 32]; in_round = 4'd0;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== ex[127-32*k -: 32]) begin
        tests_failed++; $display("FAIL kv_beat%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, ex[127-32*k -: 32]);
      end
      tests_run++;
      if (out_last !== ((k == 3) ? 1'b1 : 1'b0)) begin
        tests_failed++; $display("FAIL kv_last%0d got %b want %b", k, out_last, (k == 3));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL kv_drain got %b want 0", out_valid); end
    obs_q.delete();
  endtask

  task automatic test_wide();
    logic [127:0] st;
    out_ready_w = 1'b1; in_valid_w = 1'b1; in_data_w = ST0; in_round_w = 4'd0;
    tests_run++; if (in_ready_w !== 1'b1) begin tests_failed++; $display("FAIL wide_ready got %b want 1", in_ready_w); end
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    tests_run++;
    if (out_valid_w !== 1'b1 || out_data_w !== EXP0 || out_last_w !== 1'b1) begin
      tests_failed++; $display("FAIL wide_block got v=%b d=%h l=%b want v=1 d=%h l=1", out_valid_w, out_data_w, out_last_w, EXP0);
    end
    st = rand128();
    in_valid_w = 1'b1; in_data_w = st; in_round_w = 4'd11;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    tests_run++;
    if (out_data_w !== st || err_round_w !== 1'b1) begin
      tests_failed++; $display("FAIL wide_bad_round got d=%h e=%b want d=%h e=1", out_data_w, err_round_w, st);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid_w !== 1'b0 || err_round_w !== 1'b0) begin
      tests_failed++; $display("FAIL wide_idle got v=%b e=%b want 0 0", out_valid_w, err_round_w);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] st, ex, got;
    logic [3:0] lasts;
    logic [31:0] held;
    bit ok, all_ok;
    int err0;
    logic [127:0] exp_q[$];

    st = rand128(); ex = ref_block(st, 0); held = ex[95:64];
    obs_q.delete(); out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = st[127-32*k -: 32]; in_round = 4'd0;
      @(posedge clk); #1;
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = st[63:32]; in_round = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready); end
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== held || out_last !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold cyc%0d got v=%b d=%h l=%b want v=1 d=%h l=0", c, out_valid, out_data, out_last, held);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive_beat(st[63:32], 4'($urandom_range(0, 15)), 1'b0, ok);
    if (ok) drive_beat(st[31:0], 4'($urandom_range(0, 15)), 1'b0, ok);
    collect_block(got, lasts, all_ok);
    tests_run++;
    if (!ok || !all_ok || got !== ex || lasts !== 4'b0001) begin
      tests_failed++; $display("FAIL bp_block got %h last=%b want %h last=0001", got, lasts, ex);
    end
    repeat (4) @(negedge clk);
    tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL bp_no_dup got %0d extra beats want 0", obs_q.size()); end
    @(posedge clk); #1;

    // Random keys, rounds, gaps and out_ready over 100 blocks.
    for (int i = 0; i < NK; i++) write_key(4'(i), rand128());
    err0 = err_cnt; obs_q.delete(); all_ok = 1'b1;
    for (int b = 0; b < 100; b++) begin
      int r;
      st = rand128(); r = int'($urandom_range(0, NK - 1));
      exp_q.push_back(ref_block(st, r));
      send_block(st, 4'(r), 1'b1, ok);
      if (!ok) begin all_ok = 1'b0; break; end
    end
    out_ready = 1'b1;
    tests_run++; if (!all_ok) begin tests_failed++; $display("FAIL rand_send timeout got stalled want accepted"); end
    for (int b = 0; b < exp_q.size(); b++) begin
      collect_block(got, lasts, ok);
      tests_run++;
      if (!ok || got !== exp_q[b] || lasts !== 4'b0001) begin
        tests_failed++; $display("FAIL rand_block%0d got %h last=%b want %h last=0001", b, got, lasts, exp_q[b]);
        if (!ok) break;
      end
    end
    tests_run++; if (err_cnt != err0) begin tests_failed++; $display("FAIL rand_err got %0d pulses want 0", err_cnt - err0); end
  endtask

  task automatic test_key_rewrite();
    logic [127:0] st_a, st_b, ex_a, ex_b, newk, got;
    logic [3:0] lasts;
    bit ok;
    int wbeat;
    write_key(4'd0, K0);
    out_ready = 1'b1; obs_q.delete();
    for (int sc = 0; sc < 2; sc++) begin
      st_a = rand128(); st_b = rand128();
      newk = (sc == 0) ? {128{1'b1}} : rand128();
      wbeat = (sc == 0) ? 2 : 0;
      ex_a = ref_block(st_a, 0);
      for (int k = 0; k < 8; k++) begin
        in_valid = 1'b1;
        in_data = (k < 4) ? st_a[127-32*k -: 32] : st_b[127-32*(k-4) -: 32];
        in_round = (k == 0 || k == 4) ? 4'd0 : 4'($urandom_range(0, 15));
        key_we = (k == wbeat); key_waddr = 4'd0; key_wdata = newk;
        @(posedge clk); #1;
      end
      key_we = 1'b0; in_valid = 1'b0;
      model_key[0] = newk;
      ex_b = ref_block(st_b, 0);
      collect_block(got, lasts, ok);
      tests_run++;
      if (!ok || got !== ex_a) begin tests_failed++; $display("FAIL rewrite%0d_cur got %h want %h", sc, got, ex_a); end
      collect_block(got, lasts, ok);
      tests_run++;
      if (!ok || got !== ex_b) begin tests_failed++; $display("FAIL rewrite%0d_next got %h want %h", sc, got, ex_b); end
    end
  endtask

  task automatic test_bad_round();
    logic [127:0] st, got;
    logic [3:0] lasts;
    bit ok;
    int err0;
    write_key(4'd11, rand128());
    write_key(4'd15, rand128());
    err0 = err_cnt; obs_q.delete(); out_ready = 1'b1;
    st = rand128();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = st[127-32*k -: 32];
      in_round = (k == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      if (k == 0) begin
        tests_run++; if (err_round !== 1'b1) begin tests_failed++; $display("FAIL bad_err_pulse got %b want 1", err_round); end
      end
      if (k == 1) begin
        tests_run++; if (err_round !== 1'b0) begin tests_failed++; $display("FAIL bad_err_clear got %b want 0", err_round); end
      end
    end
    in_valid = 1'b0;
    collect_block(got, lasts, ok);
    tests_run++;
    if (!ok || got !== st || lasts !== 4'b0001) begin
      tests_failed++; $display("FAIL bad_passthru got %h last=%b want %h last=0001", got, lasts, st);
    end
    tests_run++; if (err_cnt - err0 != 1) begin tests_failed++; $display("FAIL bad_err_count got %0d want 1", err_cnt - err0); end
    for (int r = 0; r < NK; r++) begin
      st = rand128();
      send_block(st, 4'(r), 1'b0, ok);
      collect_block(got, lasts, ok);
      tests_run++;
      if (!ok || got !== ref_block(st, r)) begin
        tests_failed++; $display("FAIL bad_write_alias round%0d got %h want %h", r, got, ref_block(st, r));
      end
    end
  endtask

  task automatic test_reset_mid_block();
    logic [127:0] st, got;
    logic [3:0] lasts;
    bit ok;
    out_ready = 1'b1; obs_q.delete();
    st = rand128();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = st[127-32*k -: 32]; in_round = 4'd11;
      if (k < 2) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 || err_round !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid outputs got v=%b d=%h l=%b e=%b want all 0", out_valid, out_data, out_last, err_round);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NK; i++) model_key[i] = '0;
    obs_q.delete();
    st = rand128();
    send_block(st, 4'd3, 1'b0, ok);
    collect_block(got, lasts, ok);
    tests_run++;
    if (!ok || got !== ref_block(st, 3) || lasts !== 4'b0001) begin
      tests_failed++; $display("FAIL rst_after got %h last=%b want %h last=0001", got, lasts, ref_block(st, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b0;
    in_valid_w = 1'b0; in_data_w = '0; in_round_w = '0; out_ready_w = 1'b0;
    for (int i = 0; i < NK; i++) model_key[i] = '0;

    test_reset();
    test_known_vector();
    test_wide();
    test_backpressure();
    test_key_rewrite();
    test_bad_round();
    test_reset_mid_block();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
